// File: rtl/usr_seq_ctrl_pkg.sv
// Shared definitions for the universal shift-register sequencer: mode codes
// understood by the driven shift register and the sequencer state encoding.
package usr_pkg;

  localparam logic [1:0] SHF_HOLD  = 2'b00;
  localparam logic [1:0] SHF_LEFT  = 2'b01;
  localparam logic [1:0] SHF_RIGHT = 2'b10;
  localparam logic [1:0] SHF_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command handshake bundle for the shift-register sequencer: the producer
// uses the master modport, the sequencer uses the slave modport.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_dir,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_dir,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving a 4-bit universal shift register: one LOAD, then N shifts,
// then a done pulse. A shadow copy supplies the bit shifted out each cycle.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  usr_seq_ctrl_if.slave    cmd,
  input  logic             hold,
  output logic [1:0]       shf,
  output logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             ser_out,
  output logic             ser_valid
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             dir_q,    dir_d;
  logic [CNT_W-1:0] len_q,    len_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (cmd.cmd_len > LEN_MAX) ? LEN_MAX : cmd.cmd_len;
  assign a           = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    dir_d         = dir_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    shf           = SHF_HOLD;
    busy          = 1'b0;
    done          = 1'b0;
    ser_out       = 1'b0;
    ser_valid     = 1'b0;
    cmd.cmd_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          data_d  = cmd.cmd_data;
          dir_d   = cmd.cmd_dir;
          len_d   = len_clamped;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shf      = SHF_LOAD;
        busy     = 1'b1;
        shadow_d = data_q;
        cnt_d    = len_q;
        state_d  = (len_q == '0) ? DONE : SHIFT;
      end

      SHIFT: begin
        busy = 1'b1;
        // While paused the driven register sees HOLD, so the shadow must freeze too.
        if (!hold) begin
          ser_valid = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (dir_q) begin
            shf      = SHF_RIGHT;
            ser_out  = shadow_q[0];
            shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
          end else begin
            shf      = SHF_LEFT;
            ser_out  = shadow_q[WIDTH-1];
            shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Randomized bench for usr_seq_ctrl: a behavioural shift register follows shf/a,
// and each command's serial stream, latency and final word come from simple arithmetic.
module tb_usr_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hold;
  logic [1:0]   shf;
  logic [W-1:0] a;
  logic         busy, done, ser_out, ser_valid;

  usr_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .hold      (hold),
    .shf       (shf),
    .a         (a),
    .busy      (busy),
    .done      (done),
    .ser_out   (ser_out),
    .ser_valid (ser_valid)
  );

  always #5 clk = ~clk;

  // Model of the driven shift register (it has no reset of its own).
  logic [W-1:0] y;
  always @(posedge clk) begin
    case (shf)
      2'b01:   y <= {y[W-2:0], 1'b0};
      2'b10:   y <= {1'b0, y[W-1:1]};
      2'b11:   y <= a;
      default: y <= y;
    endcase
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_shf"},   32'(shf),           32'd0);
    chk({pfx, "_a"},     32'(a),             32'd0);
    chk({pfx, "_busy"},  32'(busy),          32'd0);
    chk({pfx, "_done"},  32'(done),          32'd0);
    chk({pfx, "_sv"},    32'(ser_valid),     32'd0);
    chk({pfx, "_so"},    32'(ser_out),       32'd0);
    chk({pfx, "_ready"}, 32'(cif.cmd_ready), 32'd1);
  endtask

  task automatic check_idle();
    chk("idle_ready", 32'(cif.cmd_ready), 32'd1);
    chk("idle_busy",  32'(busy),          32'd0);
    chk("idle_done",  32'(done),          32'd0);
    chk("idle_shf",   32'(shf),           32'd0);
    chk("idle_sv",    32'(ser_valid),     32'd0);
  endtask

  task automatic drive_noise(input bit keep_valid);
    cif.cmd_valid = keep_valid;
    cif.cmd_data  = W'($urandom);
    cif.cmd_dir   = 1'($urandom);
    cif.cmd_len   = CW'($urandom);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      drive_noise(1'b0);
      hold = 1'($urandom);
      @(negedge clk);
      check_idle();
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge while the DUT is idle.
  task automatic run_cmd(input logic [W-1:0] d, input logic dir, input logic [CW-1:0] len,
                         input logic [31:0] hmask, input bit keep_valid, input int abort_shift);
    int           n, shifts, holds, c;
    logic [W-1:0] exp_y;
    logic         exp_bit;
    n      = (int'(len) > W) ? W : int'(len);
    exp_y  = dir ? (d >> n) : (d << n);
    shifts = 0;
    holds  = 0;
    c      = 0;

    // Handshake cycle
    cif.cmd_valid = 1'b1;
    cif.cmd_data  = d;
    cif.cmd_dir   = dir;
    cif.cmd_len   = len;
    hold          = 1'($urandom);
    @(negedge clk);
    check_idle();
    @(posedge clk);
    #1;

    // LOAD cycle; hold must have no effect here
    drive_noise(keep_valid);
    hold = 1'($urandom);
    @(negedge clk);
    chk("load_shf",   32'(shf),           32'd3);
    chk("load_a",     32'(a),             32'(d));
    chk("load_busy",  32'(busy),          32'd1);
    chk("load_ready", 32'(cif.cmd_ready), 32'd0);
    chk("load_sv",    32'(ser_valid),     32'd0);
    @(posedge clk);
    #1;

    while (shifts < n) begin
      drive_noise(keep_valid);
      hold = (c < 32) ? hmask[c] : 1'b0;
      @(negedge clk);
      if (hold) begin
        holds++;
        chk("hold_shf", 32'(shf),       32'd0);
        chk("hold_sv",  32'(ser_valid), 32'd0);
      end else begin
        exp_bit = dir ? d[shifts] : d[W-1-shifts];
        chk("shift_shf", 32'(shf),       dir ? 32'd2 : 32'd1);
        chk("shift_sv",  32'(ser_valid), 32'd1);
        chk("shift_so",  32'(ser_out),   32'(exp_bit));
        shifts++;
      end
      chk("shift_busy",  32'(busy),          32'd1);
      chk("shift_ready", 32'(cif.cmd_ready), 32'd0);
      chk("shift_done",  32'(done),          32'd0);
      if (!hold && shifts == abort_shift) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        chk("abort_hold_done", 32'(done), 32'd0);
        chk("abort_hold_shf",  32'(shf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cif.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("cmd d=%b dir=%0d len=%0d aborted after %0d shifts, y=%b", d, dir, len, shifts, y);
        return;
      end
      @(posedge clk);
      #1;
      c++;
    end

    // DONE cycle
    drive_noise(keep_valid);
    hold = 1'($urandom);
    @(negedge clk);
    chk("done_pulse", 32'(done),          32'd1);
    chk("done_shf",   32'(shf),           32'd0);
    chk("done_busy",  32'(busy),          32'd1);
    chk("done_ready", 32'(cif.cmd_ready), 32'd0);
    chk("done_sv",    32'(ser_valid),     32'd0);
    chk("final_y",    32'(y),             32'(exp_y));
    $display("cmd d=%b dir=%0d len=%0d shifts=%0d holds=%0d y=%b exp_y=%b",
             d, dir, len, n, holds, y, exp_y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b1;
    hold          = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_data  = '0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_len   = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(1);

    // Directed scenarios
    run_cmd(4'b1011, 1'b0, 3'd4, 32'h0, 1'b0, 0);
    idle_cycles(1);
    run_cmd(4'b1011, 1'b1, 3'd2, 32'h0, 1'b0, 0);
    run_cmd(4'b0110, 1'b0, 3'd0, 32'h0, 1'b0, 0);
    run_cmd(4'b1101, 1'b1, 3'd7, 32'h0, 1'b0, 0);
    run_cmd(4'b1001, 1'b0, 3'd7, 32'h0, 1'b0, 0);
    run_cmd(4'b1010, 1'b0, 3'd3, 32'h6, 1'b0, 0);
    run_cmd(4'b0111, 1'b1, 3'd3, 32'h6, 1'b0, 0);
    // Continuous cmd_valid with changing data, back-to-back commands
    run_cmd(4'b1100, 1'b0, 3'd2, 32'h0, 1'b1, 0);
    run_cmd(4'b0011, 1'b1, 3'd1, 32'h0, 1'b1, 0);
    run_cmd(4'b1110, 1'b1, 3'd4, 32'h0, 1'b1, 0);
    idle_cycles(1);
    // Reset during the second shift, then a fresh command
    run_cmd(4'b1011, 1'b0, 3'd4, 32'h0, 1'b0, 2);
    idle_cycles(1);
    run_cmd(4'b1011, 1'b0, 3'd4, 32'h0, 1'b0, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0]  rd;
      logic          rdir;
      logic [CW-1:0] rlen;
      logic [31:0]   rmask;
      bit            rkeep;
      rd    = W'($urandom);
      rdir  = 1'($urandom);
      rlen  = CW'($urandom_range(0, 7));
      rmask = $urandom & $urandom;
      rkeep = 1'($urandom);
      run_cmd(rd, rdir, rlen, rmask, rkeep, 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
